// File: rtl/led_pkg.sv
// Shared definitions for the USER_LED PWM fader: default widths, the brightness
// level type and the saturating decay helper.
package led_pkg;

    localparam int LED_W_DEF = 9;
    localparam int PWM_W_DEF = 8;

    // Brightness level at the default PWM resolution.
    typedef logic [PWM_W_DEF-1:0] lvl_t;

    // Linear decay that bottoms out at zero instead of wrapping to a bright level.
    function automatic int unsigned decay_sub(input int unsigned lvl, input int unsigned step);
        return (lvl > step) ? (lvl - step) : 0;
    endfunction

endpackage

// File: rtl/led_pwm_fader_rst_sync.sv
// Two-flop reset synchronizer: reset asserts immediately (no clock needed) and
// releases cleanly on the second rising clock edge after the input goes high.
module rst_sync (
    input  logic i_clk,
    input  logic i_arst_n,
    output logic o_rst_n
);

    logic r_meta;
    logic r_sync;

    // Shift a 1 through two flops once the asynchronous reset is released.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= 1'b1;
            r_sync <= r_meta;
        end
    end

    assign o_rst_n = r_sync;

endmodule

// File: rtl/led_pwm_fader.sv
// PWM dimmer with comet-tail afterglow for the USER_LED pins. Lit pattern bits
// drive their LED at bright_max; bits that go dark fade out in linear steps.
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int LED_W       = LED_W_DEF,
    parameter int PWM_W       = PWM_W_DEF,
    parameter int DECAY_DIV_W = 16,
    parameter int DECAY_STEP  = 16
) (
    input  logic             OSC_50m,
    input  logic             FPGA_RSTn,
    input  logic [LED_W-1:0] led_in,
    input  logic             led_in_vld,
    input  logic [PWM_W-1:0] bright_max,
    output logic [LED_W-1:0] USER_LED
);

    logic                   w_rst_n;
    logic [PWM_W-1:0]       r_pwm_cnt;
    logic [DECAY_DIV_W-1:0] r_div_cnt;
    logic [LED_W-1:0]       r_pat_q;
    logic                   w_tick;
    logic [LED_W-1:0]       w_pat_eff;

    rst_sync u_rst_sync (
        .i_clk    (OSC_50m),
        .i_arst_n (FPGA_RSTn),
        .o_rst_n  (w_rst_n)
    );

    // Free-running PWM phase and decay prescaler.
    always_ff @(posedge OSC_50m or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pwm_cnt <= '0;
            r_div_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            r_div_cnt <= r_div_cnt + DECAY_DIV_W'(1);
        end
    end

    // Hold the most recent pattern delivered by the upstream generator.
    always_ff @(posedge OSC_50m or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pat_q <= '0;
        end else if (led_in_vld) begin
            r_pat_q <= led_in;
        end
    end

    // One decay step whenever the prescaler is about to wrap.
    assign w_tick    = &r_div_cnt;
    // The pattern that governs this cycle: a fresh strobe overrides the held copy.
    assign w_pat_eff = led_in_vld ? led_in : r_pat_q;

    for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
        logic [PWM_W-1:0] r_lvl;
        logic [PWM_W-1:0] w_lvl_next;
        logic             r_led;

        // Lit bits follow bright_max; unlit bits fade from wherever they are.
        always_comb begin
            w_lvl_next = r_lvl;
            if (led_in_vld && led_in[gi]) begin
                w_lvl_next = bright_max;
            end else if (!led_in_vld && r_pat_q[gi]) begin
                w_lvl_next = bright_max;
            end else if (w_tick && !w_pat_eff[gi]) begin
                w_lvl_next = PWM_W'(decay_sub(32'(r_lvl), DECAY_STEP));
            end
        end

        // Level register and registered PWM compare for this LED.
        always_ff @(posedge OSC_50m or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_lvl <= '0;
                r_led <= 1'b0;
            end else begin
                r_lvl <= w_lvl_next;
                r_led <= (r_lvl > r_pwm_cnt);
            end
        end

        assign USER_LED[gi] = r_led;
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Self-checking bench for led_pwm_fader with a short decay prescaler so fades
// complete in a few hundred cycles.
module tb_led_pwm_fader;

    localparam int LED_W = 9;
    localparam int PWM_W = 8;
    localparam int DIV_W = 4;
    localparam int STEP  = 16;

    logic             clk       = 1'b0;
    logic             rstn      = 1'b1;
    logic [LED_W-1:0] led_in    = '0;
    logic             vld       = 1'b0;
    logic [PWM_W-1:0] bright    = '0;
    logic [LED_W-1:0] user_led;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int unsigned edge_cnt;

    logic [PWM_W-1:0] lvl0, lvl1, lvl2;

    led_pwm_fader #(
        .LED_W       (LED_W),
        .PWM_W       (PWM_W),
        .DECAY_DIV_W (DIV_W),
        .DECAY_STEP  (STEP)
    ) dut (
        .OSC_50m    (clk),
        .FPGA_RSTn  (rstn),
        .led_in     (led_in),
        .led_in_vld (vld),
        .bright_max (bright),
        .USER_LED   (user_led)
    );

    assign lvl0 = dut.g_led[0].r_lvl;
    assign lvl1 = dut.g_led[1].r_lvl;
    assign lvl2 = dut.g_led[2].r_lvl;

    always #10 clk = ~clk;

    // Rising edges since the raw reset was last released.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    // Park on the negedge before a tick edge (edge numbers 18, 34, ...).
    task automatic wait_tick_cycle();
        int n = 0;
        while (!(edge_cnt >= 17 && edge_cnt % 16 == 1)) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL tick_wait: no tick cycle within 100 cycles, required one");
                return;
            end
        end
    endtask

    // Park on the negedge right after a tick edge.
    task automatic wait_after_tick();
        int n = 0;
        while (!(edge_cnt >= 18 && edge_cnt % 16 == 2)) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL tick_wait: no tick edge within 100 cycles, required one");
                return;
            end
        end
    endtask

    task automatic measure(input int bit_i, output int hi, output int other);
        logic [LED_W-1:0] mask;
        mask  = ~(9'b1 << bit_i);
        hi    = 0;
        other = 0;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            if (user_led[bit_i]) hi++;
            if ((user_led & mask) != '0) other++;
        end
    endtask

    task automatic test_reset();
        #1 rstn = 1'b0;
        #1;
        checks++;
        if (user_led !== 9'h000) begin
            errors++; $display("FAIL reset_async: USER_LED=%h required 000", user_led);
        end
        bright = 8'hFF;
        led_in = 9'h1FF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vld = (c == 2);
            checks++;
            if (user_led !== 9'h000) begin
                errors++; $display("FAIL reset_hold: cycle %0d USER_LED=%h required 000", c, user_led);
            end
        end
        @(negedge clk);
        vld  = 1'b1;
        rstn = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            exp_q.push_back((e == 4) ? 9'h1FF : 9'h000);
            checks++;
            if (user_led !== 9'(exp_q.pop_front())) begin
                errors++; $display("FAIL reset_release: edge %0d USER_LED=%h", e, user_led);
            end
            $display("release edge %0d USER_LED=%h", e, user_led);
        end
        vld = 1'b0;
        // Re-assert with all levels high: outputs must clear with no clock edge.
        #5 rstn = 1'b0;
        #1;
        checks++;
        if (user_led !== 9'h000 || lvl0 !== 8'h00) begin
            errors++; $display("FAIL reset_lit: USER_LED=%h lvl0=%0d required 000/0", user_led, lvl0);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (user_led !== 9'h000 || lvl0 !== 0 || lvl1 !== 0 || lvl2 !== 0) begin
            errors++; $display("FAIL reset_clear: USER_LED=%h lvl0=%0d lvl1=%0d required all 0", user_led, lvl0, lvl1);
        end
    endtask

    task automatic test_full_bright();
        int hi, other;
        @(negedge clk);
        bright = 8'hFF; led_in = 9'h001; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        checks++;
        if (lvl0 !== 8'hFF) begin
            errors++; $display("FAIL full_lvl: lvl0=%0d required 255", lvl0);
        end
        @(negedge clk);
        measure(0, hi, other);
        $display("full brightness duty %0d/256 others %0d", hi, other);
        checks++;
        if (hi != 255 || other != 0) begin
            errors++; $display("FAIL full_duty: high=%0d others=%0d required 255/0", hi, other);
        end
    endtask

    task automatic test_bright_change();
        int hi, other;
        @(negedge clk);
        bright = 8'h40;
        @(negedge clk);
        checks++;
        if (lvl0 !== 8'h40) begin
            errors++; $display("FAIL track_lvl: lvl0=%0d required 64", lvl0);
        end
        @(negedge clk);
        measure(0, hi, other);
        $display("brightness 0x40 duty %0d/256 others %0d", hi, other);
        checks++;
        if (hi != 64 || other != 0) begin
            errors++; $display("FAIL track_duty: high=%0d others=%0d required 64/0", hi, other);
        end
    endtask

    task automatic test_fade();
        int hi, other, exp_v;
        @(negedge clk);
        bright = 8'hFF;
        @(negedge clk);
        led_in = 9'h002; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        for (int k = 1; k <= 16; k++) exp_q.push_back((255 - 16 * k > 0) ? 255 - 16 * k : 0);
        while (exp_q.size() > 0) begin
            wait_after_tick();
            exp_v = exp_q.pop_front();
            $display("fade step lvl0=%0d expected %0d", lvl0, exp_v);
            checks++;
            if (lvl0 !== 8'(exp_v)) begin
                errors++; $display("FAIL fade_step: lvl0=%0d required %0d", lvl0, exp_v);
            end
            @(negedge clk);
        end
        checks++;
        if (lvl1 !== 8'hFF) begin
            errors++; $display("FAIL fade_lit: lvl1=%0d required 255", lvl1);
        end
        wait_after_tick();
        checks++;
        if (lvl0 !== 8'h00) begin
            errors++; $display("FAIL fade_floor: lvl0=%0d required 0", lvl0);
        end
        measure(0, hi, other);
        checks++;
        if (hi != 0 || lvl0 !== 8'h00) begin
            errors++; $display("FAIL fade_off: high=%0d lvl0=%0d required 0/0", hi, lvl0);
        end
    endtask

    task automatic test_collision();
        wait_after_tick();
        bright = 8'd100; led_in = 9'h004; vld = 1'b1;
        @(negedge clk);
        bright = 8'd200; led_in = 9'h002;
        @(negedge clk);
        vld = 1'b0;
        checks++;
        if (lvl2 !== 8'd100 || lvl1 !== 8'd200) begin
            errors++; $display("FAIL coll_setup: lvl2=%0d lvl1=%0d required 100/200", lvl2, lvl1);
        end
        wait_tick_cycle();
        bright = 8'd160; led_in = 9'h004; vld = 1'b1;
        exp_q.push_back(160);
        exp_q.push_back(184);
        @(negedge clk);
        vld = 1'b0;
        $display("collision lvl2=%0d lvl1=%0d", lvl2, lvl1);
        checks++;
        if (lvl2 !== 8'(exp_q.pop_front())) begin
            errors++; $display("FAIL coll_lit: lvl2=%0d required 160", lvl2);
        end
        checks++;
        if (lvl1 !== 8'(exp_q.pop_front())) begin
            errors++; $display("FAIL coll_decay: lvl1=%0d required 184", lvl1);
        end
        @(negedge clk);
        wait_after_tick();
        checks++;
        if (lvl1 !== 8'd168 || lvl2 !== 8'd160) begin
            errors++; $display("FAIL coll_next: lvl1=%0d lvl2=%0d required 168/160", lvl1, lvl2);
        end
    endtask

    task automatic test_reset_mid_fade();
        int hi, other, bad;
        @(negedge clk);
        led_in = 9'h000; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        for (int t = 0; t < 3; t++) begin
            wait_after_tick();
            @(negedge clk);
        end
        checks++;
        if (lvl2 !== 8'd112) begin
            errors++; $display("FAIL midfade_lvl: lvl2=%0d required 112", lvl2);
        end
        #5 rstn = 1'b0;
        #1;
        checks++;
        if (user_led !== 9'h000 || lvl2 !== 8'h00 || lvl1 !== 8'h00) begin
            errors++; $display("FAIL midfade_reset: USER_LED=%h lvl2=%0d lvl1=%0d required 000/0/0", user_led, lvl2, lvl1);
        end
        bright = 8'h50;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (user_led != '0 || lvl0 != 0 || lvl1 != 0 || lvl2 != 0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL midfade_dark: %0d cycles lit, required 0", bad);
        end
        led_in = 9'h004; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        checks++;
        if (lvl2 !== 8'h50) begin
            errors++; $display("FAIL midfade_relight: lvl2=%0d required 80", lvl2);
        end
        @(negedge clk);
        measure(2, hi, other);
        $display("relight duty %0d/256 others %0d", hi, other);
        checks++;
        if (hi != 80 || other != 0) begin
            errors++; $display("FAIL relight_duty: high=%0d others=%0d required 80/0", hi, other);
        end
    endtask

    initial begin
        test_reset();
        test_full_bright();
        test_bright_change();
        test_fade();
        test_collision();
        test_reset_mid_fade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
